// File: rtl/sparse_expander.sv
// sparse_expander: scatters a packed stream of nonzero values back into a
// dense LANES-wide vector, with lane placement taken from a nonzero-lane mask.
module sparse_expander #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int W     = IL + FL,
    parameter int LANES = 16,
    parameter int BEAT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mask_valid,
    input  logic [LANES-1:0]     mask,
    output logic                 mask_ready,
    input  logic                 in_valid,
    input  logic [BEAT*W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [LANES*W-1:0]   out_data,
    input  logic                 out_ready
);

    localparam int CW = $clog2(BEAT + 1);
    localparam int SW = (BEAT > 1) ? $clog2(BEAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [LANES-1:0]     r_pending;
    logic [LANES*W-1:0]   r_dense;
    logic                 r_mask_ready;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic [W-1:0]         w_slot [BEAT];
    logic [LANES-1:0]     w_pending_next;
    logic [LANES*W-1:0]   w_dense_next;
    logic [CW-1:0]        w_cnt;

    // Split the packed beat into its slots, slot 0 first in order.
    always_comb begin
        for (int k = 0; k < BEAT; k++) begin
            w_slot[k] = in_data[k*W +: W];
        end
    end

    // Route slot k to the k-th lowest still-pending lane; leftover slots are dropped.
    always_comb begin
        w_pending_next = r_pending;
        w_dense_next   = r_dense;
        w_cnt          = {CW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (r_pending[i] && (w_cnt < CW'(BEAT))) begin
                w_dense_next[i*W +: W] = w_slot[w_cnt[SW-1:0]];
                w_pending_next[i]      = 1'b0;
                w_cnt                  = w_cnt + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                w_cnt = w_cnt;
            end
        end
    end

    // Control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= {LANES{1'b0}};
            r_dense      <= {(LANES*W){1'b0}};
            r_mask_ready <= 1'b1;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mask_valid) begin
                        r_pending    <= mask;
                        r_dense      <= {(LANES*W){1'b0}};
                        r_mask_ready <= 1'b0;
                        if (mask == {LANES{1'b0}}) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_FILL;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        r_pending <= w_pending_next;
                        r_dense   <= w_dense_next;
                        if (w_pending_next == {LANES{1'b0}}) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_state <= ST_FILL;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state      <= ST_IDLE;
                        r_out_valid  <= 1'b0;
                        r_mask_ready <= 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pending    <= {LANES{1'b0}};
                    r_dense      <= {(LANES*W){1'b0}};
                    r_mask_ready <= 1'b1;
                    r_in_ready   <= 1'b0;
                    r_out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign mask_ready = r_mask_ready;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_dense;

endmodule

// File: tb/tb_sparse_expander.sv
// Bench for sparse_expander: directed scenarios plus randomized vectors checked
// against a lane-order scatter model.
module tb_sparse_expander;

    localparam int W     = 20;
    localparam int LANES = 16;
    localparam int BEAT  = 4;
    localparam int DW    = LANES * W;

    logic              clk;
    logic              reset;
    logic              mask_valid;
    logic [LANES-1:0]  mask;
    logic              mask_ready;
    logic              in_valid;
    logic [BEAT*W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    int n_cmp = 0;
    int n_err = 0;

    sparse_expander dut (
        .clk        (clk),
        .reset      (reset),
        .mask_valid (mask_valid),
        .mask       (mask),
        .mask_ready (mask_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the j-th set mask bit (ascending) takes the j-th value of the stream.
    function automatic logic [DW-1:0] model(input logic [LANES-1:0] m, input logic [W-1:0] vals [16]);
        logic [DW-1:0] res;
        int j;
        res = '0;
        j = 0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                res[i*W +: W] = vals[j];
                j++;
            end
        end
        return res;
    endfunction

    task automatic send_mask(input logic [LANES-1:0] m);
        check("mask_ready_idle", DW'(mask_ready), DW'(1));
        mask_valid = 1'b1;
        mask = m;
        @(negedge clk);
        mask_valid = 1'b0;
        check("mask_ready_after", DW'(mask_ready), DW'(0));
        if (m == '0) check("empty_out_valid", DW'(out_valid), DW'(1));
        else         check("fill_in_ready", DW'(in_ready), DW'(1));
    endtask

    task automatic send_beats(input logic [LANES-1:0] m, input logic [W-1:0] vals [16], input int stall);
        int nb;
        nb = ($countones(m) + BEAT - 1) / BEAT;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                for (int s = 0; s < stall; s++) begin
                    mask_valid = 1'b1;
                    mask = 16'hFFFF;
                    @(negedge clk);
                    mask_valid = 1'b0;
                    check("stall_in_ready", DW'(in_ready), DW'(1));
                    check("stall_out_valid", DW'(out_valid), DW'(0));
                end
            end
            for (int k = 0; k < BEAT; k++) in_data[k*W +: W] = vals[b*BEAT + k];
            check("beat_in_ready", DW'(in_ready), DW'(1));
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check("beat_out_valid", DW'(out_valid), DW'((b == nb - 1) ? 1 : 0));
        end
    endtask

    task automatic finish_vector(input logic [DW-1:0] exp, input int bp);
        for (int c = 0; c < bp; c++) begin
            check("bp_out_data", out_data, exp);
            check("bp_mask_ready", DW'(mask_ready), DW'(0));
            check("bp_in_ready", DW'(in_ready), DW'(0));
            mask_valid = 1'b1;
            mask = 16'h1234;
            in_valid = 1'b1;
            @(negedge clk);
            mask_valid = 1'b0;
            in_valid = 1'b0;
        end
        check("out_valid", DW'(out_valid), DW'(1));
        check("out_data", out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_mask_ready", DW'(mask_ready), DW'(1));
        check("post_out_valid", DW'(out_valid), DW'(0));
    endtask

    task automatic run_vector(input logic [LANES-1:0] m, input logic [W-1:0] vals [16], input int stall, input int bp);
        send_mask(m);
        send_beats(m, vals, stall);
        finish_vector(model(m, vals), bp);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        #1;
        check("rst_mask_ready", DW'(mask_ready), DW'(1));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] vals [16];
        logic [LANES-1:0] m;

        reset = 1'b0;
        mask_valid = 1'b0;
        mask = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        @(negedge clk);
        pulse_reset();

        // Empty mask.
        for (int i = 0; i < 16; i++) vals[i] = 20'(i + 1);
        run_vector(16'h0000, vals, 0, 0);

        // Sparse mask: two beats, last two slots dropped.
        for (int i = 0; i < 16; i++) vals[i] = 20'((i + 1) << 10);
        run_vector(16'h8C29, vals, 0, 0);
        check("sparse_lane15", DW'(model(16'h8C29, vals) >> (15 * W)), DW'(20'(6 << 10)));

        // Full mask with a 3-cycle stall and back-pressure.
        for (int i = 0; i < 16; i++) vals[i] = 20'(i << 10);
        run_vector(16'hFFFF, vals, 3, 5);

        // Signed extremes pass through bit-exact.
        vals[0] = 20'hFFFFF;
        vals[1] = 20'h80000;
        run_vector(16'h0003, vals, 0, 0);

        // Reset mid-FILL discards the partial vector.
        send_mask(16'h0003);
        in_data = {4{20'h12345}};
        @(negedge clk);
        pulse_reset();
        check("rst_no_out_valid", DW'(out_valid), DW'(0));
        vals[0] = 20'(9 << 10);
        run_vector(16'h0001, vals, 0, 0);

        // Reset while in DONE.
        send_mask(16'h0000);
        pulse_reset();

        // Randomized vectors.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 5))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            for (int i = 0; i < 16; i++) vals[i] = 20'($urandom);
            run_vector(m, vals, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sparse_expander.md
# sparse_expander

Decompression end of the sparsity datapath. The block takes a 16-bit nonzero-lane mask and a stream of packed nonzero 20-bit fixed-point values, four per beat. It scatters those values back into their original lane positions and presents one dense 16-lane vector. This reconstructs dense activations and weights from the compacted stream, for example for writeback or for a dense processing-element array.

## Interface
- IL, 4, integer bits per value
- FL, 16, fractional bits per value; W = IL+FL
- LANES, 16, dense vector lanes
- BEAT, 4, packed values per input beat
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- mask_valid  in  1  mask offered
- mask  in  LANES  bit i = 1 means lane i is nonzero and receives a packed value
- mask_ready  out  1  mask accepted when mask_valid && mask_ready
- in_valid  in  1  packed beat offered
- in_data  in  BEAT*W  slot k = in_data[k*W +: W], signed, slot 0 = first in order
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_valid  out  1  dense vector available
- out_data  out  LANES*W  lane i = out_data[i*W +: W], signed
- out_ready  in  1  vector consumed when out_valid && out_ready

## Operation
- States are IDLE, FILL and DONE. All outputs are registered or decoded from state only.
- **IDLE**
  - mask_ready = 1; in_ready = 0; out_valid = 0.
  - On mask handshake: pending ← mask, dense register ← all zeros.
  - Go to DONE if mask == 0, else go to FILL.
- **FILL**
  - in_ready = 1; mask_ready = 0; out_valid = 0.
  - On beat handshake: find the lowest min(BEAT, popcount(pending)) set bits of pending in ascending lane order. Slot k is written to the k-th of those lanes, and those bits are cleared from pending.
  - Slots beyond the remaining count are ignored.
  - When pending becomes 0 after the beat, go to DONE.
  - With in_valid = 0, everything holds and there is no timeout.
- **DONE**
  - out_valid = 1; out_data is stable and unchanged until the handshake.
  - mask_ready = 0; in_ready = 0.
  - On out_ready, go to IDLE.
- Values pass through bit-exact with no arithmetic. Lanes whose mask bit is 0 output 0. A masked lane that receives value 0 outputs 0; this is legal.
- Number of beats per vector = ceil(popcount(mask)/BEAT), from 0 to 4.
- mask_valid while not in IDLE and in_valid outside FILL are ignored; they are not latched.
- Reset, asynchronous and at any time including mid-FILL or in DONE:
  - state ← IDLE, pending ← 0, dense register ← 0.
  - Partial vectors are discarded.
  - After reset release the block accepts a fresh mask.

## Timing
- Reset values: mask_ready = 1, in_ready = 0, out_valid = 0, out_data = 0.
- The mask accepted at edge T gives in_ready = 1 from T+1. For an empty mask, out_valid = 1 from T+1.
- The last beat accepted at edge T gives out_valid = 1 from T+1. There is no combinational path from in_data to out_data.
- The out handshake at edge T gives mask_ready = 1 from T+1. This is one bubble cycle between vectors, by design.
- Minimum period per vector is 2 + beats cycles: 2 cycles for an empty mask, 6 cycles for a full mask.
- in_ready, mask_ready and out_valid never depend combinationally on any valid or ready input.

## Test plan
- **Reset:** assert reset = 0 mid-run → mask_ready = 1, in_ready = 0, out_valid = 0, out_data = 0 immediately, without waiting for a clock edge.
- **Empty mask:** mask = 16'h0000 → out_valid on the next cycle with out_data all zeros and no beats consumed. out_ready = 1 → back to IDLE.
- **Sparse mask:** mask = 16'h8C29 (lanes 0, 3, 5, 10, 11, 15).
  - Beat 1 = {1<<10, 2<<10, 3<<10, 4<<10} → lanes 0, 3, 5, 10.
  - Beat 2 = {5<<10, 6<<10, 7<<10, 8<<10} → lanes 11, 15 get 5<<10 and 6<<10; 7<<10 and 8<<10 are dropped.
  - All other lanes = 0. out_valid follows after exactly 2 beats.
- **Full mask with stalls:** mask = 16'hFFFF, 4 beats where slot value = (beat*4+k)<<10, with in_valid deasserted for 3 cycles between beats 2 and 3.
  - Lane i = i<<10.
  - in_ready stays 1 throughout FILL.
- **Back-pressure:** vector complete with out_ready = 0 for 5 cycles → out_data stable, mask_ready = 0, in_ready = 0, and a mask offered meanwhile is not accepted. out_ready = 1 → mask_ready = 1 on the next cycle.
- **Signed pass-through and reset mid-FILL:**
  - mask = 16'h0003, beat = {20'hFFFFF, 20'h80000, x, x} → lane 0 = -1 LSB, lane 1 = most-negative value.
  - Repeat with reset pulsed after the mask handshake → no out_valid. The next mask 16'h0001 with beat {9<<10, ...} yields lane 0 = 9<<10 and all other lanes 0.
